mixcolumn_seq: RTL and testbench



---
 rtl/mixcolumn_seq.sv | 121 ++++++++++++
 tb/tb_mixcolumn_seq.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mixcolumn_seq.sv
// mixcolumn_seq: column-serial AES MixColumns engine.
// One shared single-column GF(2^8) mixer processes the four state columns on
// four consecutive clocks. The finished state is held until downstream
// takes it. A bypass flag, sampled with the state, skips mixing for the final
// AES round.
//
// Ports:
//   clk        sole clock, rising edge
//   reset      asynchronous, active-high reset
//   in_valid   upstream presents in_state / in_bypass
//   in_ready   block can accept a state (IDLE only)
//   in_state   128-bit AES state; column c = in_state[127-32c -: 32], row 0 = MSB
//   in_bypass  1 = pass the state through unmixed
//   out_valid  out_state holds a finished result (DONE)
//   out_ready  downstream accepts the result
//   out_state  result, same byte order as in_state
//   busy       high while mixing or holding a result
//   col_idx    column being mixed (0 outside COL)
module mixcolumn_seq (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_bypass,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy,
  output logic [1:0]   col_idx
);

  typedef enum logic [1:0] {StIdle, StCol, StDone} state_e;

  state_e       state_q;
  logic [127:0] st_q;
  logic [1:0]   col_q;

  logic [31:0]  col_in;
  logic [31:0]  col_mixed;

  // Multiply by x (i.e. by 2) in GF(2^8) with the AES reduction polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // Select the column currently being mixed.
  always_comb begin
    col_in = st_q[127:96];
    unique case (col_q)
      2'd0: col_in = st_q[127:96];
      2'd1: col_in = st_q[95:64];
      2'd2: col_in = st_q[63:32];
      2'd3: col_in = st_q[31:0];
      default: col_in = st_q[127:96];
    endcase
  end

  // Shared single-column mixer.
  always_comb begin
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] d0, d1, d2, d3;
    a0 = col_in[31:24];
    a1 = col_in[23:16];
    a2 = col_in[15:8];
    a3 = col_in[7:0];
    d0 = xtime(a0);
    d1 = xtime(a1);
    d2 = xtime(a2);
    d3 = xtime(a3);
    col_mixed = {d0 ^ (d1 ^ a1) ^ a2 ^ a3,
                 a0 ^ d1 ^ (d2 ^ a2) ^ a3,
                 a0 ^ a1 ^ d2 ^ (d3 ^ a3),
                 (d0 ^ a0) ^ a1 ^ a2 ^ d3};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      st_q    <= '0;
      col_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            st_q    <= in_state;
            col_q   <= 2'd0;
            state_q <= in_bypass ? StDone : StCol;
          end
        end
        StCol: begin
          unique case (col_q)
            2'd0: st_q[127:96] <= col_mixed;
            2'd1: st_q[95:64]  <= col_mixed;
            2'd2: st_q[63:32]  <= col_mixed;
            2'd3: st_q[31:0]   <= col_mixed;
            default: st_q[127:96] <= col_mixed;
          endcase
          // col wraps back to 0 on the last column, leaving it clean for DONE.
          col_q <= col_q + 2'd1;
          if (col_q == 2'd3) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q == StCol) || (state_q == StDone);
  assign col_idx   = (state_q == StCol) ? col_q : 2'd0;
  assign out_state = st_q;

endmodule

// File: tb/tb_mixcolumn_seq.sv
module tb_mixcolumn_seq;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         in_bypass;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic         busy;
  logic [1:0]   col_idx;

  int n_cmp = 0;
  int n_err = 0;

  mixcolumn_seq dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .in_bypass (in_bypass),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state),
    .busy      (busy),
    .col_idx   (col_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Generic GF(2^8) multiply by shift-and-add.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p  = 8'h00;
    aa = a;
    bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  // Whole-state reference: circulant matrix {2,3,1,1} applied per column.
  function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic byp);
    logic [7:0]   coef [4];
    logic [7:0]   a    [4];
    logic [7:0]   r;
    logic [127:0] res;
    if (byp) return s;
    coef[0] = 8'd2; coef[1] = 8'd3; coef[2] = 8'd1; coef[3] = 8'd1;
    res = '0;
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 4; k++) a[k] = s[127 - 32*c - 8*k -: 8];
      for (int row = 0; row < 4; row++) begin
        r = 8'h00;
        for (int k = 0; k < 4; k++) r = r ^ gmul(coef[(k - row + 4) % 4], a[k]);
        res[127 - 32*c - 8*row -: 8] = r;
      end
    end
    return res;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic do_accept(input logic [127:0] s, input logic b);
    in_valid  = 1'b1;
    in_state  = s;
    in_bypass = b;
    for (int i = 0; i < 20 && in_ready !== 1'b1; i++) @(negedge clk);
    chk("accept_ready", {127'd0, in_ready}, 128'd1);
    @(negedge clk);
    in_valid  = 1'b0;
    in_state  = {$urandom, $urandom, $urandom, $urandom};
    in_bypass = 1'($urandom_range(0, 1));
  endtask

  localparam logic [127:0] V1 = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] R1 = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] V2 = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
  localparam logic [127:0] R2 = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;
  localparam logic [127:0] V3 = 128'h00112233_44556677_8899aabb_ccddeeff;

  logic [127:0] held;
  logic [127:0] nxt;
  logic [127:0] q [$];
  int           sent;
  int           got;
  logic         acc_pending;

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_state  = '0;
    in_bypass = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("rst_in_ready",  {127'd0, in_ready},  128'd1);
    chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
    chk("rst_out_state", out_state, 128'd0);
    chk("rst_busy",      {127'd0, busy},      128'd0);
    chk("rst_col_idx",   {126'd0, col_idx},   128'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Mixed vector 1: column sequencing and 4-edge latency.
    do_accept(V1, 1'b0);
    for (int c = 0; c < 4; c++) begin
      chk("v1_col_idx",   {126'd0, col_idx},   128'(c));
      chk("v1_busy",      {127'd0, busy},      128'd1);
      chk("v1_out_valid", {127'd0, out_valid}, 128'd0);
      @(negedge clk);
    end
    chk("v1_valid",  {127'd0, out_valid}, 128'd1);
    chk("v1_result", out_state, R1);
    chk("v1_in_ready_done", {127'd0, in_ready}, 128'd0);
    @(negedge clk);
    chk("v1_back_idle", {127'd0, in_ready}, 128'd1);

    // Mixed vector 2: exercises reduction for high bytes.
    do_accept(V2, 1'b0);
    repeat (4) @(negedge clk);
    chk("v2_valid",  {127'd0, out_valid}, 128'd1);
    chk("v2_result", out_state, R2);
    @(negedge clk);

    // Bypass: one-edge latency, state unchanged.
    do_accept(V3, 1'b1);
    chk("byp_valid",  {127'd0, out_valid}, 128'd1);
    chk("byp_result", out_state, V3);
    @(negedge clk);

    // Backpressure with a new state waiting upstream.
    out_ready = 1'b0;
    do_accept(V1, 1'b0);
    repeat (4) @(negedge clk);
    chk("bp_valid", {127'd0, out_valid}, 128'd1);
    held      = out_state;
    nxt       = {$urandom, $urandom, $urandom, $urandom};
    in_valid  = 1'b1;
    in_state  = nxt;
    in_bypass = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_hold_state", out_state, held);
      chk("bp_in_ready",   {127'd0, in_ready},  128'd0);
      chk("bp_out_valid",  {127'd0, out_valid}, 128'd1);
    end
    chk("bp_first_result", held, R1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_idle_ready", {127'd0, in_ready},  128'd1);
    chk("bp_idle_valid", {127'd0, out_valid}, 128'd0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_accepted_busy", {127'd0, busy}, 128'd1);
    repeat (3) @(negedge clk);
    @(negedge clk);
    chk("bp_second_valid",  {127'd0, out_valid}, 128'd1);
    chk("bp_second_result", out_state, ref_mix(nxt, 1'b0));
    out_ready = 1'b1;
    @(negedge clk);

    // Reset in the middle of COL at column 2.
    do_accept(V2, 1'b0);
    repeat (2) @(negedge clk);
    chk("mid_col_idx", {126'd0, col_idx}, 128'd2);
    reset = 1'b1;
    #1;
    chk("mid_rst_in_ready",  {127'd0, in_ready},  128'd1);
    chk("mid_rst_out_valid", {127'd0, out_valid}, 128'd0);
    chk("mid_rst_out_state", out_state, 128'd0);
    chk("mid_rst_busy",      {127'd0, busy},      128'd0);
    chk("mid_rst_col_idx",   {126'd0, col_idx},   128'd0);
    @(negedge clk);
    reset = 1'b0;
    do_accept(V1, 1'b0);
    repeat (4) @(negedge clk);
    chk("post_rst_valid",  {127'd0, out_valid}, 128'd1);
    chk("post_rst_result", out_state, R1);
    @(negedge clk);

    // Random stream against the reference model.
    sent        = 0;
    got         = 0;
    acc_pending = 1'b0;
    for (int cyc = 0; cyc < 20000 && got < 200; cyc++) begin
      @(negedge clk);
      if (acc_pending) begin
        in_valid    = 1'b0;
        acc_pending = 1'b0;
      end
      if (!in_valid && sent < 200 && $urandom_range(0, 3) != 0) begin
        in_valid  = 1'b1;
        in_state  = {$urandom, $urandom, $urandom, $urandom};
        in_bypass = 1'($urandom_range(0, 1));
      end
      out_ready = 1'($urandom_range(0, 1));
      if (in_valid && in_ready) begin
        q.push_back(ref_mix(in_state, in_bypass));
        sent++;
        acc_pending = 1'b1;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("rnd_unexpected_output", {127'd0, out_valid}, 128'd0);
        end else begin
          chk("rnd_result", out_state, q.pop_front());
        end
        got++;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("rnd_outputs_seen", 128'(got), 128'd200);
    chk("rnd_queue_empty",  128'(q.size()), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
